// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Brief    : Register-hazard scoreboard beside the ID stage. Tracks every
//            in-flight register write by age and result latency, producing
//            the issue stall and per-operand forwarding-stage selects.
// Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int AGEW     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs,
    input  logic [AW-1:0]   issue_rt,
    input  logic            issue_rs_used,
    input  logic            issue_rt_used,
    input  logic            issue_wen,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AGEW-1:0] issue_lat,
    input  logic [AGEW-1:0] kill_age,
    output logic            stall,
    output logic [AGEW-1:0] fwd_rs_sel,
    output logic [AGEW-1:0] fwd_rt_sel,
    output logic [NREG-1:0] pending
);

    // Oldest age an entry can hold; an entry at this age leaves WB next edge.
    localparam logic [AGEW-1:0] c_max_age = AGEW'(DEPTH - 1);
    localparam logic [AGEW-1:0] c_one     = AGEW'(1);

    logic [NREG-1:0] valid_q, valid_d;
    logic [AGEW-1:0] age_q [NREG];
    logic [AGEW-1:0] age_d [NREG];
    logic [AGEW-1:0] lat_q [NREG];
    logic [AGEW-1:0] lat_d [NREG];

    logic            w_rs_track, w_rt_track, w_rd_track;
    logic            w_rs_live, w_rt_live;
    logic            w_rs_hazard, w_rt_hazard;
    logic            w_accept;
    logic [AGEW-1:0] w_lat_eff;

    // Register 0 is hard-wired when ZERO_REG is set, so it never needs tracking.
    function automatic logic f_tracked(input logic [AW-1:0] r);
        return !((ZERO_REG != 0) && (r == '0));
    endfunction

    // Source lookup against the current (older) entries: hazards and selects.
    always_comb begin
        w_rs_track  = f_tracked(issue_rs);
        w_rt_track  = f_tracked(issue_rt);
        w_rd_track  = f_tracked(issue_rd);
        w_rs_live   = issue_rs_used & w_rs_track & valid_q[issue_rs];
        w_rt_live   = issue_rt_used & w_rt_track & valid_q[issue_rt];
        w_rs_hazard = w_rs_live & (age_q[issue_rs] < lat_q[issue_rs]);
        w_rt_hazard = w_rt_live & (age_q[issue_rt] < lat_q[issue_rt]);
        stall       = issue_valid & (w_rs_hazard | w_rt_hazard);
        fwd_rs_sel  = w_rs_live ? (age_q[issue_rs] + c_one) : '0;
        fwd_rt_sel  = w_rt_live ? (age_q[issue_rt] + c_one) : '0;
        w_accept    = issue_valid & ~stall & (kill_age == '0) & issue_wen & w_rd_track;
        if (issue_lat == '0) begin
            w_lat_eff = c_one;
        end else if (issue_lat > c_max_age) begin
            w_lat_eff = c_max_age;
        end else begin
            w_lat_eff = issue_lat;
        end
    end

    // Next entry state: kill, then retire, then age; a new issue overrides all.
    always_comb begin
        valid_d = valid_q;
        for (int r = 0; r < NREG; r++) begin
            age_d[r] = age_q[r];
            lat_d[r] = lat_q[r];
            if (valid_q[r]) begin
                if (age_q[r] < kill_age) begin
                    valid_d[r] = 1'b0;
                end else if (age_q[r] >= c_max_age) begin
                    valid_d[r] = 1'b0;
                end else begin
                    age_d[r] = age_q[r] + c_one;
                end
            end
        end
        if (w_accept) begin
            valid_d[issue_rd] = 1'b1;
            age_d[issue_rd]   = c_one;
            lat_d[issue_rd]   = w_lat_eff;
        end
    end

    // Entry storage; reset discards all in-flight state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= '0;
                lat_q[r] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= age_d[r];
                lat_q[r] <= lat_d[r];
            end
        end
    end

    assign pending = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Brief    : Self-checking bench: cycle table for a DEPTH=3 build plus a
//            hand-written DEPTH=5 sequence with a mid-stall reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    logic        clk;
    logic        v, rsu, rtu, wen;
    logic [4:0]  rs, rt, rd;

    logic        a_reset;
    logic [1:0]  a_lat, a_kill;
    logic        a_stall;
    logic [1:0]  a_sel_rs, a_sel_rt;
    logic [31:0] a_pend;

    logic        b_reset;
    logic [2:0]  b_lat, b_kill;
    logic        b_stall;
    logic [2:0]  b_sel_rs, b_sel_rt;
    logic [31:0] b_pend;

    int checks = 0;
    int failures = 0;

    issue_scoreboard #(.NREG(32), .AW(5), .DEPTH(3), .AGEW(2), .ZERO_REG(1)) u_a (
        .clk(clk), .reset(a_reset), .issue_valid(v),
        .issue_rs(rs), .issue_rt(rt), .issue_rs_used(rsu), .issue_rt_used(rtu),
        .issue_wen(wen), .issue_rd(rd), .issue_lat(a_lat), .kill_age(a_kill),
        .stall(a_stall), .fwd_rs_sel(a_sel_rs), .fwd_rt_sel(a_sel_rt), .pending(a_pend)
    );

    issue_scoreboard #(.NREG(32), .AW(5), .DEPTH(5), .AGEW(3), .ZERO_REG(1)) u_b (
        .clk(clk), .reset(b_reset), .issue_valid(v),
        .issue_rs(rs), .issue_rt(rt), .issue_rs_used(rsu), .issue_rt_used(rtu),
        .issue_wen(wen), .issue_rd(rd), .issue_lat(b_lat), .kill_age(b_kill),
        .stall(b_stall), .fwd_rs_sel(b_sel_rs), .fwd_rt_sel(b_sel_rt), .pending(b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs, rt;
        logic        rsu, rtu, wen;
        logic [4:0]  rd;
        logic [1:0]  lat, kill;
        logic        e_stall;
        logic [1:0]  e_rs, e_rt;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add(input logic r_, input logic v_, input logic [4:0] rs_, input logic rsu_,
                       input logic [4:0] rt_, input logic rtu_, input logic wen_,
                       input logic [4:0] rd_, input logic [1:0] lat_, input logic [1:0] kill_,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert,
                       input logic [31:0] ep);
        vecs[nvec].rst = r_;   vecs[nvec].v = v_;
        vecs[nvec].rs = rs_;   vecs[nvec].rsu = rsu_;
        vecs[nvec].rt = rt_;   vecs[nvec].rtu = rtu_;
        vecs[nvec].wen = wen_; vecs[nvec].rd = rd_;
        vecs[nvec].lat = lat_; vecs[nvec].kill = kill_;
        vecs[nvec].e_stall = es; vecs[nvec].e_rs = ers;
        vecs[nvec].e_rt = ert;   vecs[nvec].e_pend = ep;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive_b(input logic v_, input logic [4:0] rs_, input logic rsu_,
                           input logic [4:0] rt_, input logic rtu_, input logic wen_,
                           input logic [4:0] rd_, input logic [2:0] lat_);
        v = v_; rs = rs_; rsu = rsu_; rt = rt_; rtu = rtu_;
        wen = wen_; rd = rd_; b_lat = lat_; b_kill = 3'd0;
    endtask

    int stall_cnt;

    initial begin
        v = 0; rs = 0; rt = 0; rsu = 0; rtu = 0; wen = 0; rd = 0;
        a_lat = 0; a_kill = 0; a_reset = 1;
        b_lat = 0; b_kill = 0; b_reset = 1;

        //   rst v  rs  u  rt  u  wen rd lat kill | stall rs rt pending
        add(1, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 32'h0);           // reset
        add(0, 1,  1, 1,  2, 1, 1,  3, 1, 0,   0, 0, 0, 32'h0);           // add r3
        add(0, 1,  3, 1,  5, 1, 1,  4, 1, 0,   0, 2, 0, 32'h8);           // sub r4,r3,r5
        add(0, 1,  3, 1,  6, 1, 0,  0, 0, 0,   0, 3, 0, 32'h18);          // r3 in WB
        add(0, 1,  3, 1,  4, 1, 0,  0, 0, 0,   0, 0, 3, 32'h10);          // r3 retired
        add(0, 1,  0, 0,  0, 0, 1,  2, 2, 0,   0, 0, 0, 32'h0);           // lw r2
        add(0, 1,  1, 1,  2, 1, 1,  8, 1, 0,   1, 0, 2, 32'h4);           // load-use stall
        add(0, 1,  1, 1,  2, 1, 1,  8, 1, 0,   0, 0, 3, 32'h4);           // released
        add(0, 1,  0, 0,  0, 0, 1,  7, 2, 0,   0, 0, 0, 32'h100);         // lw r7
        add(0, 1,  0, 0,  0, 0, 1,  7, 1, 0,   0, 0, 0, 32'h180);         // add r7 (WAW)
        add(0, 1,  7, 1,  0, 0, 0,  0, 0, 0,   0, 2, 0, 32'h80);          // ALU entry wins
        add(0, 1,  0, 0,  0, 0, 1,  0, 2, 0,   0, 0, 0, 32'h80);          // write r0
        add(0, 1,  0, 1,  0, 1, 0,  0, 0, 0,   0, 0, 0, 32'h0);           // r0 untracked
        add(0, 1,  0, 0,  0, 0, 1,  9, 2, 0,   0, 0, 0, 32'h0);           // lw r9
        add(0, 1,  0, 0,  0, 0, 1, 10, 1, 2,   0, 0, 0, 32'h200);         // kill age<2, add r10
        add(0, 1,  9, 1, 10, 1, 0,  0, 0, 0,   0, 0, 0, 32'h0);           // both untracked
        add(0, 1,  0, 0,  0, 0, 1, 11, 0, 0,   0, 0, 0, 32'h0);           // lat 0 -> 1
        add(0, 1, 11, 1,  0, 0, 1, 12, 3, 0,   0, 2, 0, 32'h800);         // lat 3 -> 2
        add(0, 1, 11, 1, 12, 1, 0,  0, 0, 0,   1, 3, 2, 32'h1800);        // r12 stalls
        add(0, 1, 11, 1, 12, 1, 0,  0, 0, 0,   0, 0, 3, 32'h1000);        // clamp: one stall
        add(0, 1,  0, 0,  0, 0, 1, 13, 2, 0,   0, 0, 0, 32'h0);           // lw r13
        add(0, 1, 13, 1,  0, 0, 1, 14, 1, 1,   1, 2, 0, 32'h2000);        // stall + kill
        add(0, 1, 14, 1, 13, 1, 0,  0, 0, 0,   0, 0, 3, 32'h2000);        // r14 not issued
        add(0, 1,  0, 0,  0, 0, 1, 15, 2, 0,   0, 0, 0, 32'h0);           // lw r15
        add(0, 1, 15, 1,  0, 0, 1, 15, 1, 0,   1, 2, 0, 32'h8000);        // r15<-r15 stalls
        add(0, 1, 15, 1,  0, 0, 1, 15, 1, 0,   0, 3, 0, 32'h8000);        // uses old entry
        add(0, 1, 15, 1,  0, 0, 0,  0, 0, 0,   0, 2, 0, 32'h8000);        // new entry age 1

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            a_reset = vecs[i].rst;
            v = vecs[i].v; rs = vecs[i].rs; rsu = vecs[i].rsu;
            rt = vecs[i].rt; rtu = vecs[i].rtu; wen = vecs[i].wen;
            rd = vecs[i].rd; a_lat = vecs[i].lat; a_kill = vecs[i].kill;
            #2;
            chk($sformatf("row%0d stall", i), {31'b0, a_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("row%0d fwd_rs_sel", i), {30'b0, a_sel_rs}, {30'b0, vecs[i].e_rs});
            chk($sformatf("row%0d fwd_rt_sel", i), {30'b0, a_sel_rt}, {30'b0, vecs[i].e_rt});
            chk($sformatf("row%0d pending", i), a_pend, vecs[i].e_pend);
        end

        // DEPTH=5 build: lat 4 producer, consumer stalls three cycles then sel 5.
        @(negedge clk);
        a_reset = 1'b1;
        b_reset = 1'b1;
        drive_b(0, 0, 0, 0, 0, 0, 0, 3'd0);
        #2;
        chk("b reset stall", {31'b0, b_stall}, 32'd0);
        chk("b reset pending", b_pend, 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        drive_b(1, 0, 0, 0, 0, 1, 6, 3'd4);
        @(negedge clk);
        drive_b(1, 6, 1, 0, 0, 0, 0, 3'd0);
        stall_cnt = 0;
        #2;
        for (int c = 0; c < 10; c++) begin
            if (!b_stall) break;
            stall_cnt++;
            @(negedge clk);
            #2;
        end
        chk("b stall cycles lat4", stall_cnt, 32'd3);
        chk("b stall released", {31'b0, b_stall}, 32'd0);
        chk("b fwd_rs_sel WB", {29'b0, b_sel_rs}, 32'd5);
        chk("b pending at age4", b_pend, 32'h40);

        // Reissue, then reset during the second stall cycle.
        drive_b(1, 0, 0, 0, 0, 1, 6, 3'd4);
        @(negedge clk);
        drive_b(1, 6, 1, 0, 0, 0, 0, 3'd0);
        #2;
        chk("b stall cycle1", {31'b0, b_stall}, 32'd1);
        @(negedge clk);
        #2;
        chk("b stall cycle2", {31'b0, b_stall}, 32'd1);
        chk("b fwd_rs_sel age2", {29'b0, b_sel_rs}, 32'd3);
        b_reset = 1'b1;
        #1;
        chk("b async reset stall", {31'b0, b_stall}, 32'd0);
        chk("b async reset pending", b_pend, 32'd0);
        chk("b async reset sel", {29'b0, b_sel_rs}, 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        #2;
        chk("b after reset stall", {31'b0, b_stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised register-hazard scoreboard for the in-order pipelined MIPS cores. It sits beside the ID stage and tracks every in-flight register write by age and result latency. From that it produces the issue stall and the per-operand forwarding-stage selects. It replaces the fixed load-use stall check and the fixed two-source EX/MEM and MEM/WB forwarding unit. It adds configurable pipeline depth, per-instruction result latency (ALU, load, multi-cycle ops), write-after-write override and age-selective kill for branch and exception flushes.

## Interface
Parameters:
- NREG, 32, number of architectural registers
- AW, 5, register index width (log2 NREG)
- DEPTH, 3, stages from EX through WB inclusive; legal range 2..7
- AGEW, 2, width holding 0..DEPTH
- ZERO_REG, 1, when 1, register 0 is never tracked

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all entries
- issue_valid  in  1  instruction present in ID
- issue_rs, issue_rt  in  AW  source register indices
- issue_rs_used, issue_rt_used  in  1  source actually read by the instruction
- issue_wen  in  1  instruction writes a register
- issue_rd  in  AW  destination register index
- issue_lat  in  AGEW  result latency: age at which the result becomes forwardable (1 = ALU, 2 = load)
- kill_age  in  AGEW  flush; clears entries with age < kill_age and drops the ID issue; 0 = no kill
- stall  out  1  hold PC and IF/ID, inject a bubble into ID/EX
- fwd_rs_sel, fwd_rt_sel  out  AGEW  stage the operand is taken from when the consumer is in EX; 0 = register file, k = stage k output register
- pending  out  NREG  registered valid vector of tracked destinations

## Operation
- Per register r, an entry holds valid[r], age[r] (1..DEPTH-1) and lat[r].
- Age convention: the cycle after issue, the producer is in EX with age 1. Age increments once per cycle.
- Effective latency: issue_lat is clamped to the range 1..DEPTH-1. A value of 0 becomes 1.
- Source hazard: the source is used, its index is tracked, valid[src] is set, and age[src] < lat[src].
- stall = issue_valid & (hazard(rs) | hazard(rt)). It is combinational from the inputs and current state.
- fwd_x_sel: age[x]+1 when valid[x] and the source is used, else 0. This value is combinational and is meaningful only when stall=0.
  - Example at DEPTH=3: sel 2 is MEM, sel 3 is WB.
- Accept: issue_valid & !stall & kill_age==0 & issue_wen & tracked(issue_rd).
- Edge update, evaluated in this order:
  1. kill_age clears every entry whose current age < kill_age.
  2. Surviving entries at age DEPTH-1 retire, which clears valid. Because register-file write-through covers WB, the retired value is read from the register file.
  3. All other valid entries increment age.
  4. An accepted issue sets valid[rd]=1, age[rd]=1 and lat[rd]=clamped lat. This overrides any retire, increment or kill on the same rd, so the youngest writer wins (WAW).
- Register 0 with ZERO_REG=1: never hazards, sel always 0, never written into an entry.
- A source equal to its own rd uses the existing (older) entry for its hazard and select. The new entry takes effect next cycle.
- pending = valid vector, registered.

## Timing
- Reset: all valid=0, pending=0, stall=0, both sels=0, immediately and asynchronously. This holds mid-operation: all in-flight state is discarded.
- Latency through the block: stall and sel are zero-cycle (combinational). State changes are visible one cycle after the edge.
- ALU→dependent, back-to-back: no stall, sel=2.
- Load→dependent: one stall cycle, then sel=3.
- The worst-case stall for lat=L is L-1 cycles.
- A stalled instruction re-evaluates every cycle. There is no deadlock, because every entry either reaches age ≥ lat or retires by age DEPTH-1.
- When kill_age>0 and stall=1 in the same cycle, no issue occurs. Stall still reports hazards against the pre-kill state.

## Test plan
- Reset, then `add r3` (lat1) followed by `sub r4,r3,r5` the next cycle → stall=0, fwd_rs_sel=2. One cycle later with r3 as source → sel=3. After that → sel=0, pending[3]=0.
- `lw r2` (lat2), then a consumer of r2 → stall=1 for exactly 1 cycle, then stall=0 with fwd_rt_sel=3.
- WAW: `lw r7` issued, then `add r7` the next cycle, then a consumer of r7 → no stall, sel=2 (the ALU entry overrode the load).
- Writes to r0 with lat 2, then a consumer of r0 → stall=0, sel=0, pending=0.
- Kill: `lw r9` at age 1, kill_age=2 asserted with `add r10` in ID → r9 and r10 untracked next cycle, and a consumer of r9 does not stall.
- DEPTH=5 build, issue_lat=4: consumer stalls 3 cycles then sees sel=5. Assert reset during the 2nd stall cycle → stall drops immediately and pending=0.
